// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the scoreboard-based hazard unit:
// instruction class encodings, enable levels and the register-index width helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_DIV  = 2'd3
  } op_class_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Width of a register index for a file of n registers (never below 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_if.sv
// ID-stage / redirect / divider signal bundle between the pipeline and hazard_ctrl.
// master = pipeline side driving the request fields, slave = the hazard unit.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int REG_NUM = 32
);
  localparam int IDX_W = idx_w(REG_NUM);

  logic              id_valid_i;
  logic [IDX_W-1:0]  id_rs1_idx_i;
  logic              id_rs1_used_i;
  logic [IDX_W-1:0]  id_rs2_idx_i;
  logic              id_rs2_used_i;
  logic [IDX_W-1:0]  id_rd_idx_i;
  logic              id_rd_we_i;
  op_class_e         id_class_i;
  logic              jal_jmp_i;
  logic [ADDR_W-1:0] jal_addr_i;
  logic              br_jmp_i;
  logic [ADDR_W-1:0] br_addr_i;
  logic              div_done_i;
  logic [IDX_W-1:0]  div_rd_i;

  logic              stall_o;
  logic              redirect_o;
  logic [ADDR_W-1:0] redirect_addr_o;
  logic              flush_if_o;
  logic              flush_id_o;
  logic              div_busy_o;
  logic [31:0]       stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_idx_i, id_rs1_used_i, id_rs2_idx_i, id_rs2_used_i,
           id_rd_idx_i, id_rd_we_i, id_class_i, jal_jmp_i, jal_addr_i,
           br_jmp_i, br_addr_i, div_done_i, div_rd_i,
    input  stall_o, redirect_o, redirect_addr_o, flush_if_o, flush_id_o,
           div_busy_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_idx_i, id_rs1_used_i, id_rs2_idx_i, id_rs2_used_i,
           id_rd_idx_i, id_rd_we_i, id_class_i, jal_jmp_i, jal_addr_i,
           br_jmp_i, br_addr_i, div_done_i, div_rd_i,
    output stall_o, redirect_o, redirect_addr_o, flush_if_o, flush_id_o,
           div_busy_o, stall_cnt_o
  );

endinterface : hazard_ctrl_if

// File: rtl/hazard_scoreboard.sv
// Per-register pending counters plus divider tracking; reports which ID operands
// are not yet forwardable and whether the ID instruction collides with the divider.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter  int REG_NUM  = 32,
  parameter  int LOAD_LAT = 1,
  parameter  int MUL_LAT  = 2,
  parameter  int CNT_W    = 2,
  localparam int IDX_W    = idx_w(REG_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_issue,
  input  op_class_e        i_class,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic             i_rd_we,
  input  logic [IDX_W-1:0] i_rs1_idx,
  input  logic             i_rs1_used,
  input  logic [IDX_W-1:0] i_rs2_idx,
  input  logic             i_rs2_used,
  input  logic             i_div_done,
  input  logic [IDX_W-1:0] i_div_rd,
  output logic             o_rs1_blocked,
  output logic             o_rs2_blocked,
  output logic             o_waw,
  output logic             o_struct,
  output logic             o_div_pend
);

  logic [CNT_W-1:0] r_cnt [REG_NUM];
  logic             r_div_pend;
  logic [IDX_W-1:0] r_div_rd_q;

  logic [CNT_W-1:0] w_issue_lat;
  logic             w_rd_write;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_issue_lat = '0;
    unique case (i_class)
      CLS_LOAD: w_issue_lat = CNT_W'(LOAD_LAT);
      CLS_MUL:  w_issue_lat = CNT_W'(MUL_LAT);
      default:  w_issue_lat = '0;
    endcase
  end

  // The divider result is tracked separately, so DIV never touches the counters.
  assign w_rd_write = i_issue && i_rd_we && (i_rd_idx != '0) && (i_class != CLS_DIV);

  // NOTE: the counter array is a few dozen flops, not a RAM, so it is reset
  // like any other state; a stale count after reset would stall the first issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_cnt[i] <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int i = 1; i < REG_NUM; i++) begin
        // NOTE: sequential state uses non-blocking assignment so every counter
        // samples the pre-edge values regardless of statement order.
        if (w_rd_write && (i_rd_idx == IDX_W'(i))) r_cnt[i] <= w_issue_lat;
        else if (r_cnt[i] != '0)                   r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // A DIV issue wins over a simultaneous completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_pend <= DISABLE;
      r_div_rd_q <= '0;
    end else if (i_issue && (i_class == CLS_DIV)) begin
      r_div_pend <= ENABLE;
      r_div_rd_q <= i_rd_idx;
    end else if (i_div_done && (i_div_rd == r_div_rd_q)) begin
      r_div_pend <= DISABLE;
    end
  end

  always_comb begin
    o_rs1_blocked = i_rs1_used && (i_rs1_idx != '0) &&
                    ((r_cnt[i_rs1_idx] != '0) || (r_div_pend && (r_div_rd_q == i_rs1_idx)));
    o_rs2_blocked = i_rs2_used && (i_rs2_idx != '0) &&
                    ((r_cnt[i_rs2_idx] != '0) || (r_div_pend && (r_div_rd_q == i_rs2_idx)));
    o_waw         = i_rd_we && r_div_pend && (i_rd_idx == r_div_rd_q) && (i_rd_idx != '0);
    o_struct      = (i_class == CLS_DIV) && r_div_pend;
    o_div_pend    = r_div_pend;
  end

endmodule : hazard_scoreboard

// File: rtl/hazard_ctrl.sv
// Hazard unit beside ID: combines scoreboard hazards into the ID stall, resolves
// EX-branch vs ID-JAL redirect priority, drives front-end flushes, counts stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int CNT_W    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  logic        w_rs1_blocked;
  logic        w_rs2_blocked;
  logic        w_waw;
  logic        w_struct;
  logic        w_div_pend;
  logic        w_stall;
  logic        w_issue;
  logic [31:0] r_stall_cnt;

  hazard_scoreboard #(
    .REG_NUM  (REG_NUM),
    .LOAD_LAT (LOAD_LAT),
    .MUL_LAT  (MUL_LAT),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue       (w_issue),
    .i_class       (bus.id_class_i),
    .i_rd_idx      (bus.id_rd_idx_i),
    .i_rd_we       (bus.id_rd_we_i),
    .i_rs1_idx     (bus.id_rs1_idx_i),
    .i_rs1_used    (bus.id_rs1_used_i),
    .i_rs2_idx     (bus.id_rs2_idx_i),
    .i_rs2_used    (bus.id_rs2_used_i),
    .i_div_done    (bus.div_done_i),
    .i_div_rd      (bus.div_rd_i),
    .o_rs1_blocked (w_rs1_blocked),
    .o_rs2_blocked (w_rs2_blocked),
    .o_waw         (w_waw),
    .o_struct      (w_struct),
    .o_div_pend    (w_div_pend)
  );

  // An EX redirect kills the ID instruction, so it must never also stall it.
  assign w_stall = bus.id_valid_i && !bus.br_jmp_i &&
                   (w_rs1_blocked || w_rs2_blocked || w_waw || w_struct);
  assign w_issue = bus.id_valid_i && !w_stall && !bus.br_jmp_i;

  always_comb begin
    bus.redirect_o      = DISABLE;
    bus.redirect_addr_o = '0;
    bus.flush_if_o      = DISABLE;
    bus.flush_id_o      = DISABLE;
    if (bus.br_jmp_i) begin
      bus.redirect_o      = ENABLE;
      bus.redirect_addr_o = bus.br_addr_i;
      bus.flush_if_o      = ENABLE;
      bus.flush_id_o      = ENABLE;
    end else if (bus.jal_jmp_i && bus.id_valid_i && !w_stall) begin
      bus.redirect_o      = ENABLE;
      bus.redirect_addr_o = bus.jal_addr_i;
      bus.flush_if_o      = ENABLE;
    end else if (w_stall) begin
      bus.flush_id_o      = ENABLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign bus.stall_o     = w_stall;
  assign bus.div_busy_o  = w_div_pend;
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule : hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised scoreboard-based hazard unit for the in-order RISC-V pipeline.
- Replaces the fixed single-bubble load-use check with per-register pending counters.
  - Configurable LOAD and MUL latencies.
  - Tracks a variable-latency divider.
- Prioritises EX-stage branch redirects over ID-stage JAL redirects and issues front-end flushes.
- Sits beside the ID stage; drives PC select, IF/ID flush and the ID stall.

Parameters:
- ADDR_W, 32, PC/target address width.
- REG_NUM, 32, architectural register count (x0 hard-wired zero).
- LOAD_LAT, 1, cycles after issue before a load result is forwardable (1 = one bubble for an adjacent consumer).
- MUL_LAT, 2, same for multiply class.
- CNT_W, 2, counter width; must satisfy 2^CNT_W-1 >= max(LOAD_LAT, MUL_LAT).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  valid instruction in ID.
- id_rs1_idx_i  in  log2(REG_NUM)  rs1 index.
- id_rs1_used_i  in  1  rs1 is read.
- id_rs2_idx_i  in  log2(REG_NUM)  rs2 index.
- id_rs2_used_i  in  1  rs2 is read.
- id_rd_idx_i  in  log2(REG_NUM)  rd index.
- id_rd_we_i  in  1  instruction writes rd.
- id_class_i  in  2  0=ALU, 1=LOAD, 2=MUL, 3=DIV.
- jal_jmp_i  in  1  ID-stage JAL taken.
- jal_addr_i  in  ADDR_W  JAL target.
- br_jmp_i  in  1  EX-stage branch/JALR redirect.
- br_addr_i  in  ADDR_W  EX target.
- div_done_i  in  1  divider writeback this cycle.
- div_rd_i  in  log2(REG_NUM)  divider destination.
- stall_o  out  1  hold PC and IF/ID.
- redirect_o  out  1  load PC with redirect_addr_o.
- redirect_addr_o  out  ADDR_W  target.
- flush_if_o  out  1  kill IF/ID register.
- flush_id_o  out  1  kill ID/EX register (insert bubble).
- div_busy_o  out  1  divider result pending.
- stall_cnt_o  out  32  total stall cycles since reset.

Behaviour:
State:
- cnt[REG_NUM] of CNT_W bits.
- div_pend and div_rd_q registers.
- 32-bit stall counter.
- Everything clears to 0 on rst_n low, asynchronously. cnt[0] is always 0.

Operand readiness:
- rsN is blocked if rsN_used && idx!=0 && (cnt[idx]!=0 || (div_pend && div_rd_q==idx)).

Stall (combinational):
- stall_o = id_valid_i && !br_jmp_i && (rs1 blocked || rs2 blocked || waw || struct).
- waw: id_rd_we_i && div_pend && id_rd_idx_i==div_rd_q && id_rd_idx_i!=0.
- struct: id_class_i==DIV && div_pend.

Issue:
- issue = id_valid_i && !stall_o && !br_jmp_i.
- On issue with id_rd_we_i and rd!=0:
  - LOAD: cnt[rd] <= LOAD_LAT.
  - MUL: cnt[rd] <= MUL_LAT.
  - ALU: cnt[rd] <= 0.
- On issue with DIV class: div_pend <= 1, div_rd_q <= id_rd_idx_i.
  - rd==0 still sets div_pend, giving structural tracking only; readiness ignores x0.

Counter update:
- Every cycle, each nonzero cnt decrements by 1, including during stalls.
- On the same register, an issue write overrides the decrement.

Divider completion:
- div_done_i clears div_pend next edge. No same-cycle bypass: a blocked consumer proceeds the cycle after div_done_i.
- div_done_i with div_rd_i!=div_rd_q is ignored; the bench flags it as a protocol error.
- div_done_i and a DIV issue in the same cycle cannot happen (struct stall). If both are asserted, set wins.

Redirect priority (combinational):
- br_jmp_i:
  - redirect_o=1, redirect_addr_o=br_addr_i.
  - flush_if_o=1, flush_id_o=1.
  - No scoreboard update from ID.
- else jal_jmp_i && id_valid_i && !stall_o:
  - redirect_o=1, redirect_addr_o=jal_addr_i.
  - flush_if_o=1, flush_id_o=0.
  - JAL issues normally as ALU class.
- else stall_o: flush_id_o=1 (bubble), redirect_o=0.
- Otherwise all 0, redirect_addr_o=0.

Other outputs:
- stall_cnt_o increments on every cycle with stall_o=1 and wraps at 2^32.
- div_busy_o = div_pend.
- Reset mid-operation drops all pending state; the first post-reset instruction is never stalled.

Decomposition:
- Shared package/defines:
  - class encodings ALU/LOAD/MUL/DIV.
  - REG_IDX width macro.
  - ENABLE/DISABLE.
- One natural sub-module: hazard_scoreboard.
  - Holds cnt array, div_pend/div_rd_q.
  - Outputs the per-source blocked flags.
- The top keeps stall/redirect priority and the stall counter.

Test Plan:
- LOAD x5 issued, next cycle ADD reads x5 (LOAD_LAT=1).
  - stall_o=1 exactly 1 cycle, flush_id_o=1 that cycle.
  - Issue the following cycle; stall_cnt_o=1.
- MUL x7 (MUL_LAT=2), consumer of x7 next cycle.
  - stall 2 cycles.
  - Consumer with one independent instruction in between: stall 1 cycle.
- DIV x9, consumer of x9 next cycle, div_done_i pulsed 6 cycles later.
  - Stall until the cycle after div_done_i.
  - div_busy_o high throughout.
  - A second DIV while busy stalls (struct).
- br_jmp_i=1 (addr 0x100) and jal_jmp_i=1 (addr 0x200) simultaneously, while ID holds a stalled load-use.
  - redirect_addr_o=0x100, flush_if_o=flush_id_o=1, stall_o=0.
  - No scoreboard update.
- Instructions writing x0 with LOAD class, then a consumer reading x0: no stall.
- Assert rst_n low while cnt[5]=1 and div_pend=1.
  - All outputs 0 immediately.
  - After release, a consumer of x5/x9 issues without stall.
